clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
- Sequencer for the programmable clock divider. Owns the divider's division value and its active-low async reset.
- Changes the division ratio through a glitch-safe sequence:
  1. gate the divided clock off;
  2. hold the divider in reset while the new value is loaded;
  3. release reset and let the divider settle;
  4. re-enable the gate.
- Sits in the clocking subsystem between a register/config master (valid/ready request port) and one divider instance plus its downstream clock gate.

Parameters:
- DIV_WIDTH, 4, width of the division value; matches the divider's divide input width.
- RESET_DIV, 4, division value driven after reset (DIV_WIDTH bits).
- GATE_CYCLES, 2, cycles the gate is held off before the divider is reset (>=1).
- RESET_CYCLES, 2, cycles the divider is held in reset (>=1).
- SETTLE_CYCLES, 4, cycles after reset release before the gate is re-enabled (>=1).

Ports:
- clk_i  input  1  controller clock; same clock that feeds the divider.
- arst_i  input  1  asynchronous reset, active-high.
- req_div_i  input  DIV_WIDTH  requested division value.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  controller can accept a request.
- div_o  output  DIV_WIDTH  division value to the divider's divide input.
- div_arst_no  output  1  active-low async reset to the divider.
- gate_en_o  output  1  enable for the downstream clock gate on the divided clock.
- busy_o  output  1  a reconfiguration sequence is in progress.
- done_o  output  1  one-cycle pulse when a request has completed.

Behaviour:
- All state and outputs are registered on the rising edge of clk_i. Every output is a direct function of registered state.
- States: RST, SETTLE, RUN, GATE.
- One down-counter:
  - Loaded with (phase cycles - 1) on entry to a phase.
  - Decrements each edge while nonzero.
  - The phase exits on the edge where the counter is 0, so each phase lasts exactly its parameter in cycles.
  - Counter width is $clog2 of the largest phase parameter + 1.
- Reset (arst_i=1, asynchronous), also applies mid-sequence:
  - State = RST, counter = RESET_CYCLES-1, div_o = RESET_DIV.
  - div_arst_no=0, gate_en_o=0, req_ready_o=0, busy_o=1, done_o=0.
  - Any captured request is discarded.
- After reset release the controller walks RST -> SETTLE -> RUN. No done_o pulse is generated for this power-on sequence.
- Outputs per state:
  - RST: div_arst_no=0, gate_en_o=0, busy_o=1, req_ready_o=0.
  - SETTLE: div_arst_no=1, gate_en_o=0, busy_o=1, req_ready_o=0.
  - RUN: div_arst_no=1, gate_en_o=1, busy_o=0, req_ready_o=1.
  - GATE: div_arst_no=1, gate_en_o=0, busy_o=1, req_ready_o=0.
- Handshake: a request is accepted on an edge where req_valid_i & req_ready_o.
  - req_div_i is captured into a pending register at that edge.
  - req_valid_i/req_div_i are ignored while req_ready_o=0. The requester must hold them until accepted.
- Accept with req_div_i != div_o: RUN -> GATE (counter = GATE_CYCLES-1).
- GATE exit: div_o <= pending value, then state -> RST (counter = RESET_CYCLES-1).
  - div_o changes only on this transition or at reset, so it is always stable while div_arst_no=1.
- RST exit: state -> SETTLE (counter = SETTLE_CYCLES-1).
- SETTLE exit: state -> RUN.
  - done_o=1 for the first RUN cycle only, and only if the sequence was request-initiated (a flag set on accept, cleared on the done pulse).
- Accept with req_div_i == div_o: state stays RUN, gate stays enabled, done_o=1 in the next cycle.
- Latency from accept edge H to done:
  - A full sequence enters RUN at edge H+GATE_CYCLES+RESET_CYCLES+SETTLE_CYCLES; done_o is high in the following cycle.
  - A same-value request has done_o high in the cycle after H.
- Back-to-back requests: req_ready_o is 1 in the cycle done_o is high, so a new request may be accepted in that cycle.
- req_div_i = 0 is a legal value and is sequenced like any other value.

Test Plan:
- Power-on (default parameters): deassert arst_i; call the first rising edge after deassertion E1 -> div_arst_no=0 and div_o=4 through E2; div_arst_no=1 after E2; gate_en_o=1 and req_ready_o=1 after E6; done_o never pulses.
- Change 4 -> 7, handshake at edge H:
  - gate_en_o=0 after H;
  - div_o=7 and div_arst_no=0 after H+2;
  - div_arst_no=1 after H+4;
  - gate_en_o=1 after H+8, with done_o high in exactly that one cycle;
  - busy_o=1 over (H, H+8].
- Same-value request (div_o=7, req_div_i=7): no gate drop and no divider reset; done_o high in the cycle after the handshake.
- Request held while busy: req_valid_i=1 with req_div_i=3 during GATE -> not accepted until RUN; accepted in the done_o cycle; a second full sequence then completes with div_o=3.
- Mid-sequence reset: assert arst_i during SETTLE of a 7 -> 2 change -> immediately div_o=4, div_arst_no=0, gate_en_o=0; power-on timing repeats; no done_o pulse.
- Zero divide: request 0 from div_o=4 -> full sequence completes with div_o=0 and done_o pulsing.

Source files
------------

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | clk_div_ctrl: glitch-safe reprogramming sequencer for a clock divider      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module clk_div_ctrl #(
  parameter int unsigned DIV_WIDTH     = 4,
  parameter int unsigned RESET_DIV     = 4,
  parameter int unsigned GATE_CYCLES   = 2,
  parameter int unsigned RESET_CYCLES  = 2,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic [DIV_WIDTH-1:0] req_div_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  output logic [DIV_WIDTH-1:0] div_o,
  output logic                 div_arst_no,
  output logic                 gate_en_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned c_max_gr  = (GATE_CYCLES > RESET_CYCLES) ? GATE_CYCLES : RESET_CYCLES;
  localparam int unsigned c_max_cyc = (c_max_gr > SETTLE_CYCLES) ? c_max_gr : SETTLE_CYCLES;
  localparam int unsigned c_cnt_w   = $clog2(c_max_cyc) + 1;

  localparam logic [c_cnt_w-1:0]   c_gate_ld   = c_cnt_w'(GATE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0]   c_reset_ld  = c_cnt_w'(RESET_CYCLES - 1);
  localparam logic [c_cnt_w-1:0]   c_settle_ld = c_cnt_w'(SETTLE_CYCLES - 1);
  localparam logic [DIV_WIDTH-1:0] c_reset_div = DIV_WIDTH'(RESET_DIV);

  typedef enum logic [1:0] {
    ST_RST    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2,
    ST_GATE   = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] r_pend;
  logic                 r_req_act;
  logic                 r_div_arst_n;
  logic                 r_gate_en;
  logic                 r_busy;
  logic                 r_ready;
  logic                 r_done;

  wire w_cnt_zero = (r_cnt == '0);
  wire w_accept   = req_valid_i & r_ready;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state      <= ST_RST;
      r_cnt        <= c_reset_ld;
      r_div        <= c_reset_div;
      r_pend       <= c_reset_div;
      r_req_act    <= 1'b0;
      r_div_arst_n <= 1'b0;
      r_gate_en    <= 1'b0;
      r_busy       <= 1'b1;
      r_ready      <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_RST: begin
          if (w_cnt_zero) begin
            r_state      <= ST_SETTLE;
            r_cnt        <= c_settle_ld;
            r_div_arst_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_SETTLE: begin
          if (w_cnt_zero) begin
            // Power-on settling never sets r_req_act, so no done pulse for it.
            r_state   <= ST_RUN;
            r_gate_en <= 1'b1;
            r_busy    <= 1'b0;
            r_ready   <= 1'b1;
            r_done    <= r_req_act;
            r_req_act <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            r_pend <= req_div_i;
            if (req_div_i == r_div) begin
              r_done <= 1'b1;
            end else begin
              r_state   <= ST_GATE;
              r_cnt     <= c_gate_ld;
              r_gate_en <= 1'b0;
              r_busy    <= 1'b1;
              r_ready   <= 1'b0;
              r_req_act <= 1'b1;
            end
          end
        end
        ST_GATE: begin
          if (w_cnt_zero) begin
            // The divide value only moves while the divider is held in reset.
            r_div        <= r_pend;
            r_state      <= ST_RST;
            r_cnt        <= c_reset_ld;
            r_div_arst_n <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state      <= ST_RST;
          r_cnt        <= c_reset_ld;
          r_div_arst_n <= 1'b0;
          r_gate_en    <= 1'b0;
          r_busy       <= 1'b1;
          r_ready      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = r_ready;
  assign div_o       = r_div;
  assign div_arst_no = r_div_arst_n;
  assign gate_en_o   = r_gate_en;
  assign busy_o      = r_busy;
  assign done_o      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_clk_div_ctrl: scoreboard bench with a phase-arithmetic reference model  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_clk_div_ctrl;

  localparam int DW  = 4;
  localparam int RD  = 4;
  localparam int GC  = 2;
  localparam int RC  = 2;
  localparam int SC  = 4;
  localparam int TOT = GC + RC + SC;

  logic          clk_i = 1'b0;
  logic          arst_i = 1'b1;
  logic [DW-1:0] req_div_i = '0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [DW-1:0] div_o;
  logic          div_arst_no;
  logic          gate_en_o;
  logic          busy_o;
  logic          done_o;

  clk_div_ctrl #(
    .DIV_WIDTH    (DW),
    .RESET_DIV    (RD),
    .GATE_CYCLES  (GC),
    .RESET_CYCLES (RC),
    .SETTLE_CYCLES(SC)
  ) u_dut (
    .clk_i      (clk_i),
    .arst_i     (arst_i),
    .req_div_i  (req_div_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .div_o      (div_o),
    .div_arst_no(div_arst_no),
    .gate_en_o  (gate_en_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [DW-1:0] div;
    int            edge_n;
  } exp_t;

  exp_t          sb_q[$];
  int            errors = 0;
  int            checks = 0;

  // Reference model: position p = edges since a sequence anchor; phases are
  // contiguous windows [0,GC) gate, [GC,GC+RC) reset, then settle, then run.
  int            n = 0;
  int            m_start = -GC;
  logic [DW-1:0] m_div_cur = DW'(RD);
  logic [DW-1:0] m_div_new = DW'(RD);
  int            acc_cnt = 0;
  int            p_mon;
  exp_t          e_mon;

  always @(posedge arst_i) begin
    m_start   = n - GC;
    m_div_cur = DW'(RD);
    m_div_new = DW'(RD);
    sb_q.delete();
  end

  always @(posedge clk_i) begin
    exp_t e;
    if (arst_i) begin
      n = n + 1;
      m_start   = n - GC;
      m_div_cur = DW'(RD);
      m_div_new = DW'(RD);
      sb_q.delete();
    end else begin
      if ((n - m_start) >= TOT && req_valid_i) begin
        e.div = req_div_i;
        if (req_div_i == m_div_new) begin
          e.edge_n = n + 1;
        end else begin
          m_div_cur = m_div_new;
          m_div_new = req_div_i;
          m_start   = n + 1;
          e.edge_n  = n + 1 + TOT;
        end
        sb_q.push_back(e);
        acc_cnt = acc_cnt + 1;
      end
      n = n + 1;
    end
  end

  always @(negedge clk_i) begin
    logic [DW-1:0] x_div;
    logic          x_rn, x_gate, x_busy, x_rdy;
    p_mon  = n - m_start;
    x_div  = (p_mon < GC) ? m_div_cur : m_div_new;
    x_rn   = !(p_mon >= GC && p_mon < GC + RC);
    x_gate = (p_mon >= TOT);
    x_busy = (p_mon < TOT);
    x_rdy  = (p_mon >= TOT);
    checks = checks + 1;
    if ({div_o, div_arst_no, gate_en_o, busy_o, req_ready_o} !==
        {x_div, x_rn, x_gate, x_busy, x_rdy}) begin
      errors = errors + 1;
      $display("FAIL status edge=%0d got div=%0d rn=%b gate=%b busy=%b rdy=%b want div=%0d rn=%b gate=%b busy=%b rdy=%b",
               n, div_o, div_arst_no, gate_en_o, busy_o, req_ready_o,
               x_div, x_rn, x_gate, x_busy, x_rdy);
    end
    if (done_o !== 1'b0) begin
      checks = checks + 1;
      if (sb_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_done edge=%0d got done=%b want done=0", n, done_o);
      end else begin
        e_mon = sb_q.pop_front();
        if (div_o !== e_mon.div || n != e_mon.edge_n) begin
          errors = errors + 1;
          $display("FAIL done_match got div=%0d edge=%0d want div=%0d edge=%0d",
                   div_o, n, e_mon.div, e_mon.edge_n);
        end
      end
    end
    if (sb_q.size() > 0 && n > sb_q[0].edge_n) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL missing_done got none by edge=%0d want done at edge=%0d", n, sb_q[0].edge_n);
      void'(sb_q.pop_front());
    end
  end

  task automatic send(input logic [DW-1:0] d);
    int  a0;
    bit  ok;
    a0 = acc_cnt;
    ok = 1'b0;
    req_div_i   = d;
    req_valid_i = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk_i);
      if (acc_cnt != a0) ok = 1'b1;
    end
    req_valid_i = 1'b0;
    if (!ok) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL accept_timeout got no accept want accept of div=%0d", d);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (((n - m_start) <= TOT || sb_q.size() != 0) && k < 100) begin
      @(negedge clk_i);
      k++;
    end
    if (k >= 100) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL idle_timeout got busy after %0d cycles want idle", k);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] r;
    repeat (3) @(negedge clk_i);
    arst_i = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk_i);

    send(4'd7);
    send(4'd3);
    wait_idle();
    send(4'd3);
    wait_idle();
    repeat (2) @(negedge clk_i);

    send(4'd2);
    repeat (5) @(negedge clk_i);
    #2 arst_i = 1'b1;
    #1;
    checks = checks + 1;
    if ({div_o, div_arst_no, gate_en_o, busy_o, req_ready_o, done_o} !==
        {4'(RD), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors = errors + 1;
      $display("FAIL async_reset got div=%0d rn=%b gate=%b busy=%b rdy=%b done=%b want div=%0d rn=0 gate=0 busy=1 rdy=0 done=0",
               div_o, div_arst_no, gate_en_o, busy_o, req_ready_o, done_o, RD);
    end
    repeat (3) @(negedge clk_i);
    arst_i = 1'b0;
    wait_idle();

    send(4'd0);
    wait_idle();

    for (int t = 0; t < 25; t++) begin
      r = DW'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = m_div_new;
      repeat ($urandom_range(0, 10)) @(negedge clk_i);
      send(r);
    end
    wait_idle();
    repeat (3) @(negedge clk_i);

    checks = checks + 1;
    if (sb_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
